// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one full-adder slice plus a carry flop.
// Adds two WIDTH-bit operands and a carry-in LSB first over WIDTH clock cycles,
// with a start/busy/done handshake toward the controlling logic.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the o_ovf port and its
// two's-complement overflow register.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [WIDTH-1:0] r_shA;
  logic [WIDTH-1:0] r_shB;
  logic [WIDTH-1:0] r_shS;
  logic             r_carry;
  logic [CNT_W-1:0] r_bitCnt;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_faSum;
  logic             w_faCarry;
  logic [WIDTH-1:0] w_shSNext;
  logic             w_lastBit;
  logic             w_accept;
  logic             w_running;

  // Single full-adder slice working on the current LSBs and the carry flop.
  always_comb begin
    w_faSum   = r_shA[0] ^ r_shB[0] ^ r_carry;
    w_faCarry = (r_shA[0] & r_shB[0]) | (r_carry & (r_shA[0] ^ r_shB[0]));
  end

  assign w_shSNext = {w_faSum, r_shS[WIDTH-1:1]};
  assign w_lastBit = (r_bitCnt == CNT_W'(WIDTH - 1));
  assign w_accept  = (r_state == IDLE) && i_start;
  assign w_running = (r_state == RUN);

  // Next-state logic: RUN lasts WIDTH edges, DONE always lasts exactly one.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_nextState = RUN;
      RUN:     if (w_lastBit) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // busy and done registered from the next state so no input reaches them combinationally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_nextState != IDLE);
      r_done <= (w_nextState == DONE);
    end
  end

  // Operand capture on acceptance, then one shift per RUN edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shA    <= '0;
      r_shB    <= '0;
      r_shS    <= '0;
      r_carry  <= 1'b0;
      r_bitCnt <= '0;
    end else if (w_accept) begin
      r_shA    <= i_a;
      r_shB    <= i_b;
      r_shS    <= '0;
      r_carry  <= i_cin;
      r_bitCnt <= '0;
    end else if (w_running) begin
      r_shA    <= {1'b0, r_shA[WIDTH-1:1]};
      r_shB    <= {1'b0, r_shB[WIDTH-1:1]};
      r_shS    <= w_shSNext;
      r_carry  <= w_faCarry;
      r_bitCnt <= r_bitCnt + CNT_W'(1);
    end
  end

  // Result registers update only on the last RUN edge and hold otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_running && w_lastBit) begin
      r_sum  <= w_shSNext;
      r_cout <= w_faCarry;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_running && w_lastBit) begin
      r_ovf <= r_carry ^ w_faCarry;
    end
  end

  assign o_ovf = r_ovf;
`endif

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven and scoreboard checks for serial_adder,
// an 8-bit instance for directed cases and a 4-bit instance for the full sweep.
`timescale 1ns/1ps
module tb_serial_adder;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8     = '0;
  logic [7:0] b8     = '0;
  logic       cin8   = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4 = 1'b0;
  logic [3:0] a4     = '0;
  logic [3:0] b4     = '0;
  logic       cin4   = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf4;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec8_t;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp8_t;

  typedef struct packed {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } exp4_t;

  exp8_t q8[$];
  exp4_t q4[$];
  exp8_t m8;
  exp4_t m4;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start8),
    .i_a     (a8),
    .i_b     (b8),
    .i_cin   (cin8),
    .o_busy  (busy8),
    .o_done  (done8),
    .o_sum   (sum8),
    .o_cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .o_ovf   (ovf8)
`endif
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start4),
    .i_a     (a4),
    .i_b     (b4),
    .i_cin   (cin4),
    .o_busy  (busy4),
    .o_done  (done4),
    .o_sum   (sum4),
    .o_cout  (cout4)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .o_ovf   (ovf4)
`endif
  );

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic vec8_t mkVec(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                  input logic [7:0] s, input logic co, input logic ov);
    vec8_t v;
    v.a = a; v.b = b; v.cin = cin; v.sum = s; v.cout = co; v.ovf = ov;
    return v;
  endfunction

  task automatic push8(input logic [7:0] s, input logic co, input logic ov);
    exp8_t e;
    e.sum = s; e.cout = co; e.ovf = ov;
    q8.push_back(e);
  endtask

  // Scoreboard for the 8-bit instance: every done pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done8: done=1 with no pending operation, required done=0");
      end else begin
        m8 = q8.pop_front();
        checkOutput("sum8", 32'(sum8), 32'(m8.sum));
        checkOutput("cout8", 32'(cout8), 32'(m8.cout));
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("ovf8", 32'(ovf8), 32'(m8.ovf));
`endif
      end
    end
  end

  // Scoreboard for the 4-bit instance.
  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done4: done=1 with no pending operation, required done=0");
      end else begin
        m4 = q4.pop_front();
        checkOutput("sum4", 32'(sum4), 32'(m4.sum));
        checkOutput("cout4", 32'(cout4), 32'(m4.cout));
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("ovf4", 32'(ovf4), 32'(m4.ovf));
`endif
      end
    end
  end

  task automatic waitDone8(input int budget);
    int k;
    k = 0;
    while (!done8 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done8) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_done8: done=0 after %0d cycles, required done=1", budget);
    end
  endtask

  task automatic waitDone4(input int budget);
    int k;
    k = 0;
    while (!done4 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done4) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_done4: done=0 after %0d cycles, required done=1", budget);
    end
  endtask

  // One full 8-bit operation from an idle DUT: drive, expect, wait for done.
  task automatic applyStimulus(input vec8_t v);
    @(negedge clk);
    a8 = v.a; b8 = v.b; cin8 = v.cin; start8 = 1'b1;
    push8(v.sum, v.cout, v.ovf);
    @(negedge clk);
    start8 = 1'b0;
    waitDone8(20);
    @(negedge clk);
  endtask

  // One 4-bit operation with the expected value taken from the arithmetic model.
  task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] tot;
    exp4_t e;
    tot    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    e.sum  = tot[3:0];
    e.cout = tot[4];
    e.ovf  = (a[3] == b[3]) && (tot[3] != a[3]);
    @(negedge clk);
    a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
    waitDone4(12);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec8_t vecs [9];
    int    cyc;
    int    lastCyc;
    int    nDone;
    logic  prevDone;

    vecs[0] = mkVec(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1);
    vecs[1] = mkVec(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    vecs[2] = mkVec(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    vecs[3] = mkVec(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    vecs[4] = mkVec(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    vecs[5] = mkVec(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    vecs[6] = mkVec(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    vecs[7] = mkVec(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    vecs[8] = mkVec(8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy8", 32'(busy8), 32'd0);
    checkOutput("reset_done8", 32'(done8), 32'd0);
    checkOutput("reset_sum8", 32'(sum8), 32'd0);
    checkOutput("reset_cout8", 32'(cout8), 32'd0);
    checkOutput("reset_busy4", 32'(busy4), 32'd0);
    checkOutput("reset_done4", 32'(done4), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("reset_ovf8", 32'(ovf8), 32'd0);
`endif
    rst_n = 1'b1;

    $display("[TB] basic add with latency");
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b0; start8 = 1'b1;
    push8(8'h96, 1'b0, 1'b1);
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("busy_after_accept", 32'(busy8), 32'd1);
    cyc = 1;
    while (!done8 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("done_latency", 32'(cyc), 32'd9);
    checkOutput("busy_during_done", 32'(busy8), 32'd1);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done8), 32'd0);
    checkOutput("busy_fall", 32'(busy8), 32'd0);

    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
    end

    $display("[TB] reset mid-run");
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy8), 32'd0);
    checkOutput("abort_done", 32'(done8), 32'd0);
    checkOutput("abort_sum", 32'(sum8), 32'd0);
    checkOutput("abort_cout", 32'(cout8), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("abort_ovf", 32'(ovf8), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nDone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) nDone++;
    end
    checkOutput("no_done_after_abort", 32'(nDone), 32'd0);
    applyStimulus(mkVec(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0));

    $display("[TB] start held high");
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
    push8(8'h47, 1'b0, 1'b0);
    push8(8'h47, 1'b0, 1'b0);
    push8(8'h47, 1'b0, 1'b0);
    cyc = 0; lastCyc = 0; nDone = 0; prevDone = 1'b0;
    while (nDone < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (prevDone) checkOutput("held_done_width", 32'(done8), 32'd0);
      prevDone = done8;
      if (done8) begin
        if (nDone > 0) checkOutput("held_done_spacing", 32'(cyc - lastCyc), 32'd10);
        lastCyc = cyc;
        nDone++;
        if (nDone == 3) start8 = 1'b0;
      end
    end
    checkOutput("held_done_count", 32'(nDone), 32'd3);
    @(negedge clk);
    checkOutput("held_last_width", 32'(done8), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("held_stopped", 32'(busy8), 32'd0);

    $display("[TB] inputs toggled during run");
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h3C; cin8 = 1'b1; start8 = 1'b1;
    push8(8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      cin8   = 1'($urandom_range(0, 1));
      start8 = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    start8 = 1'b0;
    waitDone8(10);
    @(negedge clk);

    $display("[TB] exhaustive 4-bit sweep");
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          applyStimulus4(4'(ia), 4'(ib), 1'(ic));
        end
      end
    end

    repeat (3) @(negedge clk);
    checkOutput("q8_drained", 32'(q8.size()), 32'd0);
    checkOutput("q4_drained", 32'(q4.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
